// File: rtl/program_issuer.sv
// ============================================================================
// Module   : program_issuer
// Purpose  : Buffers instruction words and replays them as start/write/program
//            strobes into simple_processor, paced by proc_busy and a min gap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_issuer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 23,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  input  logic               clear,
  input  logic               run,
  input  logic               abort,
  input  logic               proc_busy,
  output logic               start,
  output logic               write,
  output logic [INSTR_W-1:0] program_out,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    count,
  output logic               done
);

  localparam int               c_gap_w    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [ADDR_W:0]  c_depth    = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_gap_w-1:0] c_gap_init = c_gap_w'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state, w_nxt_state;
  logic                 r_start, w_nxt_start;
  logic                 r_write, w_nxt_write;
  logic                 r_done, w_nxt_done;
  logic [INSTR_W-1:0]   r_prog, w_nxt_prog;
  // One extra bit so a full buffer can be told apart from an empty pc
  logic [ADDR_W:0]      r_pc, w_nxt_pc;
  logic [ADDR_W:0]      r_count, w_nxt_count;
  logic [c_gap_w-1:0]   r_gap, w_nxt_gap;
  logic [INSTR_W-1:0]   r_mem [DEPTH];

  logic                 w_load_ready;
  logic                 w_load_acc;
  logic [ADDR_W:0]      w_eff_count;

  assign w_load_ready = (r_state == S_IDLE) && (r_count < c_depth) && !clear;
  assign w_load_acc   = load_valid && w_load_ready;
  assign w_eff_count  = clear ? '0 : (r_count + {{ADDR_W{1'b0}}, w_load_acc});

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_start = r_start;
    w_nxt_write = 1'b0;
    w_nxt_done  = 1'b0;
    w_nxt_prog  = r_prog;
    w_nxt_pc    = r_pc;
    w_nxt_count = r_count;
    w_nxt_gap   = r_gap;
    if (abort && (r_state != S_IDLE)) begin
      w_nxt_state = S_IDLE;
      w_nxt_start = 1'b0;
      w_nxt_pc    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            w_nxt_count = '0;
            w_nxt_pc    = '0;
          end else if (w_load_acc) begin
            w_nxt_count = w_eff_count;
          end
          if (run) begin
            if (w_eff_count != '0) begin
              w_nxt_state = S_ISSUE;
              w_nxt_start = 1'b1;
              w_nxt_pc    = '0;
            end else begin
              w_nxt_state = S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (!proc_busy) begin
            w_nxt_write = 1'b1;
            w_nxt_prog  = r_mem[r_pc[ADDR_W-1:0]];
            w_nxt_pc    = r_pc + 1'b1;
            w_nxt_gap   = c_gap_init;
            w_nxt_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_gap == '0) begin
            w_nxt_state = (r_pc < r_count) ? S_ISSUE : S_DONE;
          end else begin
            w_nxt_gap = r_gap - 1'b1;
          end
        end
        S_DONE: begin
          w_nxt_done  = 1'b1;
          w_nxt_start = 1'b0;
          w_nxt_pc    = '0;
          w_nxt_state = S_IDLE;
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_prog  <= '0;
      r_pc    <= '0;
      r_count <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_start <= w_nxt_start;
      r_write <= w_nxt_write;
      r_done  <= w_nxt_done;
      r_prog  <= w_nxt_prog;
      r_pc    <= w_nxt_pc;
      r_count <= w_nxt_count;
      r_gap   <= w_nxt_gap;
    end
  end

  // Buffer storage carries no reset; contents are meaningless until loaded
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_mem[r_count[ADDR_W-1:0]] <= load_data;
    end
  end

  assign load_ready  = w_load_ready;
  assign start       = r_start;
  assign write       = r_write;
  assign program_out = r_prog;
  assign pc          = r_pc[ADDR_W-1:0];
  assign count       = r_count;
  assign done        = r_done;

endmodule

`default_nettype wire
